// File: rtl/mailbox_reg_arbiter.sv
// Round-robin arbiter sharing one register-interface slave between NumReq masters.
// Optional BUSY watchdog enabled by defining MAILBOX_ARB_TIMEOUT_EN.

package mailbox_reg_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module mailbox_reg_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 256,
  parameter type reg_req_t = mailbox_reg_arbiter_pkg::reg_req_t,
  parameter type reg_rsp_t = mailbox_reg_arbiter_pkg::reg_rsp_t,
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  reg_req_t        reg_req_i [NumReq],
  output reg_rsp_t        reg_rsp_o [NumReq],
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            busy_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [IdxW-1:0] gnt_idx_reg, gnt_idx_next;
  logic [IdxW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IdxW-1:0] sel_idx, cand_idx, gnt_inc;
  logic            sel_found;
  logic            busy, complete, timeout;
  reg_req_t        gnt_req;
  reg_rsp_t        gnt_rsp;

  assign busy     = (state_reg == BUSY);
  assign gnt_req  = reg_req_i[gnt_idx_reg];
  assign complete = busy && gnt_req.valid && reg_rsp_i.ready;
  assign gnt_inc  = (gnt_idx_reg == IdxW'(NumReq - 1)) ? '0 : gnt_idx_reg + 1'b1;

`ifdef MAILBOX_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] tmo_cnt_reg, tmo_cnt_next;

  // A same-cycle completion wins; a dropped valid is an abort, not a timeout.
  assign timeout = busy && gnt_req.valid && !reg_rsp_i.ready &&
                   (tmo_cnt_reg == CntW'(TimeoutCycles));

  always_comb begin
    tmo_cnt_next = '0;
    if (busy) tmo_cnt_next = tmo_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_cnt_reg <= '0;
    else         tmo_cnt_reg <= tmo_cnt_next;
  end
`else
  logic unused_tmo_cfg;
  assign timeout        = 1'b0;
  assign unused_tmo_cfg = |TimeoutCycles;
`endif

  // First valid requester scanning upward from rr_ptr, wrapping at NumReq.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand_idx = IdxW'((32'(rr_ptr_reg) + off) % NumReq);
      if (!sel_found && reg_req_i[cand_idx].valid) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_idx_next = gnt_idx_reg;
    rr_ptr_next  = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          gnt_idx_next = sel_idx;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (complete || timeout) begin
          rr_ptr_next = gnt_inc;
          state_next  = IDLE;
        end else if (!gnt_req.valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave response only reaches the master while its request is still valid.
  always_comb begin
    reg_req_o = '0;
    gnt_rsp   = '0;
    if (busy) begin
      reg_req_o = gnt_req;
      if (gnt_req.valid) gnt_rsp = reg_rsp_i;
      if (timeout) begin
        reg_req_o.valid = 1'b0;
        gnt_rsp         = '0;
        gnt_rsp.ready   = 1'b1;
        gnt_rsp.error   = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_rsp
      assign reg_rsp_o[gi] = (busy && (gnt_idx_reg == IdxW'(gi))) ? gnt_rsp : '0;
    end
  endgenerate

  assign busy_o    = busy;
  assign gnt_idx_o = gnt_idx_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      gnt_idx_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_idx_reg <= gnt_idx_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_mailbox_reg_arbiter.sv
// Directed self-checking bench for mailbox_reg_arbiter (NumReq=3, TimeoutCycles=4).
module tb_mailbox_reg_arbiter;
  import mailbox_reg_arbiter_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  reg_req_t   req_i [N];
  reg_rsp_t   rsp_o [N];
  reg_req_t   req_o;
  reg_rsp_t   rsp_i;
  logic [1:0] gnt;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mailbox_reg_arbiter #(.NumReq(N), .TimeoutCycles(4)) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .reg_req_i (req_i),
    .reg_rsp_o (rsp_o),
    .reg_req_o (req_o),
    .reg_rsp_i (rsp_i),
    .gnt_idx_o (gnt),
    .busy_o    (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [2:0] readies();
    return {rsp_o[2].ready, rsp_o[1].ready, rsp_o[0].ready};
  endfunction

  function automatic logic any_rsp();
    return |{rsp_o[0], rsp_o[1], rsp_o[2]};
  endfunction

  int exp_g [4] = '{0, 1, 2, 0};
  int g;

  initial begin
    rst_n = 1'b0;
    rsp_i = '0;
    for (int k = 0; k < N; k++) req_i[k] = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_req_o", 64'(|req_o), 64'd0);
    chk("rst_rsp_o", 64'(any_rsp()), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Three masters reading continuously, slave always ready: 0,1,2,0.
    tick();
    for (int k = 0; k < N; k++) begin
      req_i[k].addr  = 32'h100 + 32'(4 * k);
      req_i[k].valid = 1'b1;
    end
    rsp_i.rdata = 32'hA5;
    rsp_i.ready = 1'b1;
    #1;
    chk("rr_idle_valid", 64'(req_o.valid), 64'd0);
    chk("rr_idle_ready", 64'(readies()), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      g = exp_g[k];
      chk("rr_gnt", 64'(gnt), 64'(g));
      chk("rr_busy", 64'(busy), 64'd1);
      chk("rr_addr", 64'(req_o.addr), 64'(32'h100 + 32'(4 * g)));
      chk("rr_ready", 64'(readies()), 64'(3'b001 << g));
      chk("rr_rdata", 64'(rsp_o[g].rdata), 64'h0A5);
      chk("rr_other_rdata", 64'(rsp_o[(g + 1) % N].rdata), 64'd0);
      $display("txn rr: grant=%0d addr=%0h rdata=%0h", gnt, req_o.addr, rsp_o[g].rdata);
      tick();
      if (k == 3) for (int j = 0; j < N; j++) req_i[j].valid = 1'b0;
      #1;
      chk("rr_bubble_busy", 64'(busy), 64'd0);
      chk("rr_bubble_ready", 64'(readies()), 64'd0);
    end

    // Single master 0 write, slave ready immediately.
    rsp_i = '0;
    rsp_i.ready = 1'b1;
    req_i[0] = '0;
    req_i[0].addr  = 32'h10;
    req_i[0].write = 1'b1;
    req_i[0].wdata = 32'hCAFE0001;
    req_i[0].wstrb = 4'hF;
    req_i[0].valid = 1'b1;
    #1;
    chk("wr_c0_valid", 64'(req_o.valid), 64'd0);
    tick();
    #1;
    chk("wr_c1_valid", 64'(req_o.valid), 64'd1);
    chk("wr_c1_addr", 64'(req_o.addr), 64'h10);
    chk("wr_c1_wdata", 64'(req_o.wdata), 64'hCAFE0001);
    chk("wr_c1_write", 64'(req_o.write), 64'd1);
    chk("wr_c1_wstrb", 64'(req_o.wstrb), 64'hF);
    chk("wr_c1_ready", 64'(readies()), 64'b001);
    $display("txn write: grant=%0d addr=%0h wdata=%0h", gnt, req_o.addr, req_o.wdata);
    tick();
    req_i[0].valid = 1'b0;
    #1;
    chk("wr_c2_busy", 64'(busy), 64'd0);
    chk("wr_c2_ready", 64'(readies()), 64'd0);

    // Master 1 granted, slave stalls 5 cycles while master 0 waits.
    rsp_i = '0;
    req_i[0] = '0;
    req_i[0].addr  = 32'h200;
    req_i[0].valid = 1'b1;
    req_i[1] = '0;
    req_i[1].addr  = 32'h204;
    req_i[1].valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) rsp_i.ready = 1'b1;
      #1;
      chk("st_gnt", 64'(gnt), 64'd1);
      chk("st_addr", 64'(req_o.addr), 64'h204);
      chk("st_valid", 64'(req_o.valid), 64'd1);
      chk("st_ready", 64'(readies()), (c == 6) ? 64'b010 : 64'd0);
    end
    $display("txn stall: grant=1 completed after 6 busy cycles");
    tick();
    req_i[1].valid = 1'b0;
    rsp_i.ready = 1'b0;
    #1;
    chk("st_bubble_busy", 64'(busy), 64'd0);
    tick();
    #1;
    chk("st_next_gnt", 64'(gnt), 64'd0);
    chk("st_next_addr", 64'(req_o.addr), 64'h200);
    rsp_i.ready = 1'b1;
    #1;
    chk("st_next_ready", 64'(readies()), 64'b001);
    $display("txn stall-next: grant=%0d addr=%0h", gnt, req_o.addr);
    tick();
    req_i[0].valid = 1'b0;
    rsp_i.ready = 1'b0;
    #1;
    chk("st_end_busy", 64'(busy), 64'd0);

    // Master 1 drops valid before ready: abort, rr_ptr stays at 1.
    req_i[1].addr  = 32'h300;
    req_i[1].valid = 1'b1;
    tick();
    #1;
    chk("ab_gnt", 64'(gnt), 64'd1);
    tick();
    req_i[1].valid = 1'b0;
    rsp_i.ready = 1'b1;
    #1;
    chk("ab_busy", 64'(busy), 64'd1);
    chk("ab_req_valid", 64'(req_o.valid), 64'd0);
    chk("ab_ready", 64'(readies()), 64'd0);
    tick();
    rsp_i.ready = 1'b0;
    #1;
    chk("ab_idle", 64'(busy), 64'd0);
    req_i[0].valid = 1'b1;
    req_i[1].valid = 1'b1;
    tick();
    #1;
    chk("ab_ptr_gnt", 64'(gnt), 64'd1);
    rsp_i.ready = 1'b1;
    #1;
    chk("ab_ptr_ready", 64'(readies()), 64'b010);
    $display("txn abort-retry: grant=%0d", gnt);
    tick();
    req_i[0].valid = 1'b0;
    req_i[1].valid = 1'b0;
    rsp_i.ready = 1'b0;
    #1;
    chk("ab_end_busy", 64'(busy), 64'd0);

    // Master 2 granted, slave never ready.
    req_i[2].addr  = 32'h400;
    req_i[2].valid = 1'b1;
    rsp_i.rdata = 32'h5555;
`ifdef MAILBOX_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      chk("to_wait_busy", 64'(busy), 64'd1);
      chk("to_wait_ready", 64'(readies()), 64'd0);
      chk("to_wait_valid", 64'(req_o.valid), 64'd1);
    end
    tick();
    #1;
    chk("to_valid", 64'(req_o.valid), 64'd0);
    chk("to_ready", 64'(rsp_o[2].ready), 64'd1);
    chk("to_error", 64'(rsp_o[2].error), 64'd1);
    chk("to_rdata", 64'(rsp_o[2].rdata), 64'd0);
    $display("txn timeout: grant=%0d error=%0d", gnt, rsp_o[2].error);
    tick();
    req_i[1].valid = 1'b1;
    #1;
    chk("to_bubble", 64'(busy), 64'd0);
    tick();
    #1;
    chk("to_next_gnt", 64'(gnt), 64'd1);
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
      #1;
      chk("nt_busy", 64'(busy), 64'd1);
    end
    chk("nt_ready", 64'(readies()), 64'd0);
    $display("txn no-timeout: still busy after 100 cycles, grant=%0d", gnt);
    tick();
    req_i[2].valid = 1'b0;
    #1;
    chk("nt_drop_ready", 64'(readies()), 64'd0);
    tick();
    req_i[1].valid = 1'b1;
    #1;
    chk("nt_idle", 64'(busy), 64'd0);
    tick();
    #1;
    chk("nt_next_gnt", 64'(gnt), 64'd1);
`endif

    // Reset mid-transaction clears outputs at once; first grant afterwards is 0.
    rsp_i = '0;
    rsp_i.ready = 1'b1;
    #1;
    chk("rb_pre_ready", 64'(rsp_o[1].ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rb_busy", 64'(busy), 64'd0);
    chk("rb_req_o", 64'(|req_o), 64'd0);
    chk("rb_rsp_o", 64'(any_rsp()), 64'd0);
    chk("rb_gnt", 64'(gnt), 64'd0);
    $display("txn reset: aborted in flight");
    tick();
    rsp_i = '0;
    for (int k = 0; k < N; k++) req_i[k].valid = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("rb_idle", 64'(busy), 64'd0);
    tick();
    #1;
    chk("rb_first_gnt", 64'(gnt), 64'd0);
    chk("rb_first_busy", 64'(busy), 64'd1);
    for (int k = 0; k < N; k++) req_i[k].valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
